// File: rtl/instr_fetch_unit.sv
// Instruction supplier for a single-cycle MIPS core: loadable instruction memory, PC and a
// fetch/issue sequencer with free-run and single-step modes. NOP (32'h0) is driven when not issuing.
module instr_fetch_unit #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic [31:0]       In,
  output logic              instr_valid,
  output logic [ADDR_W+1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_idx;
  logic [ADDR_W-1:0] pc_idx_nxt;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;
  logic              mem_we;

  // Program memory is only writable while the sequencer is parked in IDLE; contents survive reset.
  assign mem_we  = (state == S_IDLE) && load_en && !reset;
  assign rd_word = mem[pc_idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_idx_nxt = pc_idx;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // The sentinel ends the run without ever reaching the core.
        if (rd_word == HALT_WORD) state_nxt = S_HALT;
        else                      state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (pc_idx == LAST_IDX) begin
          state_nxt = S_HALT;
        end else begin
          pc_idx_nxt = pc_idx + 1'b1;
          state_nxt  = step_mode ? S_WAIT : S_FETCH;
        end
      end
      S_WAIT: begin
        if (step || !step_mode) state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          state_nxt  = S_FETCH;
          pc_idx_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc_idx      <= '0;
      In          <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_idx      <= pc_idx_nxt;
      In          <= (state_nxt == S_ISSUE) ? rd_word : 32'h0;
      instr_valid <= (state_nxt == S_ISSUE);
      busy        <= (state_nxt == S_FETCH) || (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
      done        <= (state_nxt == S_HALT);
    end
  end

  assign pc        = {pc_idx, 2'b00};
  assign fsm_state = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: load, free-run, single-step, end of memory,
// ignored loads while busy, mid-run reset and restart from HALT.
module tb_instr_fetch_unit;

  localparam int          ADDR_W = 6;
  localparam logic [31:0] HALT_W = 32'hFFFFFFFF;
  localparam int          BUDGET = 400;

  logic              clk;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic              step_mode;
  logic              step;
  logic [31:0]       In;
  logic              instr_valid;
  logic [ADDR_W+1:0] pc;
  logic              busy;
  logic              done;
  logic [2:0]        fsm_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prog [4];

  instr_fetch_unit #(.ADDR_W(ADDR_W), .HALT_WORD(HALT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .In          (In),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic push_prog();
    for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
  endtask

  // Pulse start, then follow a free run: each issue must match the expected queue, land on cycle
  // 2n+1 after the start edge with pc = 4n, and In must be 0 in every other cycle.
  task automatic run_free(input string tag, input int exp_done_cyc, input int exp_final_pc,
                          input int inject_cyc);
    int cyc;
    int n;
    logic [31:0] w;
    cyc = 0;
    n   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_pc"}, 32'(pc), 32'(0));
    check({tag, "_start_busy"}, 32'(busy), 32'(1));
    while (!done && cyc < BUDGET) begin
      if (cyc == inject_cyc) begin
        load_en   = 1'b1;
        load_addr = 6'd3;
        load_data = 32'h12345678;
      end
      tick();
      load_en = 1'b0;
      cyc++;
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_issue"}, In, 32'hDEAD_0000);
        end else begin
          w = exp_q.pop_front();
          check({tag, "_word"}, In, w);
          check({tag, "_issue_cyc"}, 32'(cyc), 32'(2 * n + 1));
          check({tag, "_issue_pc"}, 32'(pc), 32'(4 * n));
          n++;
        end
      end else begin
        check({tag, "_nop"}, In, 32'h0);
      end
    end
    check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_done_cyc));
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_busy_off"}, 32'(busy), 32'(0));
    check({tag, "_final_pc"}, 32'(pc), 32'(exp_final_pc));
    check({tag, "_left"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; step_mode = 1'b0; step = 1'b0;
    prog[0] = 32'h8C010000;
    prog[1] = 32'h8C020004;
    prog[2] = 32'h00221820;
    prog[3] = HALT_W;

    do_reset();
    check("rst_in", In, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'(0));
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));

    // T1: free run of 3 words + HALT
    for (int i = 0; i < 4; i++) load_word(6'(i), prog[i]);
    push_prog();
    run_free("t1", 7, 12, -1);

    // T6: restart from HALT re-issues from word 0
    push_prog();
    run_free("t6", 7, 12, -1);

    // T2: single-step mode
    do_reset();
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t2_w0", In, prog[0]);
    check("t2_w0_valid", 32'(instr_valid), 32'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_wait_in", In, 32'h0);
      check("t2_wait_valid", 32'(instr_valid), 32'(0));
    end
    check("t2_wait_busy", 32'(busy), 32'(1));
    check("t2_wait_pc", 32'(pc), 32'(4));
    for (int i = 1; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      check("t2_fetch_valid", 32'(instr_valid), 32'(0));
      tick();
      check("t2_step_word", In, prog[i]);
      check("t2_step_valid", 32'(instr_valid), 32'(1));
      tick();
      check("t2_after_in", In, 32'h0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("t2_halt_done", 32'(done), 32'(1));
    check("t2_halt_pc", 32'(pc), 32'(12));
    step_mode = 1'b0;

    // T4: load during run ignored; second run still sees HALT at word 3
    do_reset();
    push_prog();
    run_free("t4a", 7, 12, 4);
    push_prog();
    run_free("t4b", 7, 12, -1);

    // T5: reset during ISSUE of word 1
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("t5_w1", In, prog[1]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_in", In, 32'h0);
    check("t5_valid", 32'(instr_valid), 32'(0));
    check("t5_pc", 32'(pc), 32'(0));
    check("t5_done", 32'(done), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    push_prog();
    run_free("t5", 7, 12, -1);

    // load_en and start on the same edge: FETCH reads the freshly written word
    do_reset();
    load_en = 1'b1; load_addr = 6'd0; load_data = 32'hAABBCCDD; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    check("ls_word", In, 32'hAABBCCDD);
    check("ls_valid", 32'(instr_valid), 32'(1));
    do_reset();

    // T3: all 64 words non-halt, run stops at end of memory
    for (int i = 0; i < 64; i++) begin
      load_word(6'(i), 32'h00000020);
      exp_q.push_back(32'h00000020);
    end
    run_free("t3", 128, 252, -1);
    for (int i = 0; i < 3; i++) tick();
    check("t3_pc_hold", 32'(pc), 32'(252));
    check("t3_done_hold", 32'(done), 32'(1));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
